// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multi-cycle controller and the shared
// instruction/data memory port.
//   mem_req   : controller -> memory, request held until mem_ready
//   mem_we    : controller -> memory, 1 = store, 0 = read
//   mem_ready : memory -> controller, access completes this cycle
// Modports: master (controller side), slave (memory side).
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I datapath. Steps the shared datapath through
// IDLE/FETCH/DECODE/EXEC/MEM/WB from the one-hot opcode-class flags of the type decoder.
// Build option: define CTRL_ILLEGAL_TRAP_EN to halt on an illegal opcode (err_cause 1);
// when it is undefined an illegal opcode behaves as a NOP (PC+4, no retire).
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   r_i .. uj_jal_i     opcode-class flags, sampled in DECODE
//   branch_taken_i      branch comparator result, used in EXEC
//   mem                 memory handshake (master modport)
//   ir_we_o, pc_we_o    IR / PC load enables
//   pc_sel_o            0=PC+4 1=PC+imm 2=rs1+imm
//   reg_we_o, wb_sel_o  regfile write enable, writeback select 0=ALU 1=mem 2=PC+4
//   alu_src_a_o/b_o     ALU operand selects (a: 0=rs1 1=PC, b: 0=rs2 1=imm)
//   halted_o, err_cause_o, state_o, retired_o  status (registered)
module multicycle_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 r_i,
    input  logic                 i_i,
    input  logic                 i_load_i,
    input  logic                 i_jalr_i,
    input  logic                 s_i,
    input  logic                 sb_i,
    input  logic                 u_auipc_i,
    input  logic                 u_lui_i,
    input  logic                 uj_jal_i,
    input  logic                 branch_taken_i,
    multicycle_ctrl_if.master    mem,
    output logic                 ir_we_o,
    output logic                 pc_we_o,
    output logic [1:0]           pc_sel_o,
    output logic                 reg_we_o,
    output logic [1:0]           wb_sel_o,
    output logic                 alu_src_a_o,
    output logic                 alu_src_b_o,
    output logic                 halted_o,
    output logic [1:0]           err_cause_o,
    output logic [2:0]           state_o,
    output logic [CNT_W-1:0]     retired_o
);
    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StFetch  = 3'd1;
    localparam logic [2:0] StDecode = 3'd2;
    localparam logic [2:0] StExec   = 3'd3;
    localparam logic [2:0] StMem    = 3'd4;
    localparam logic [2:0] StWb     = 3'd5;
    localparam logic [2:0] StHalt   = 3'd6;

    // Class latch bit positions; higher index = higher decode priority.
    localparam int unsigned ClJal   = 0;
    localparam int unsigned ClLui   = 1;
    localparam int unsigned ClAuipc = 2;
    localparam int unsigned ClSb    = 3;
    localparam int unsigned ClS     = 4;
    localparam int unsigned ClJalr  = 5;
    localparam int unsigned ClLoad  = 6;
    localparam int unsigned ClR     = 8;

    localparam int unsigned  ToW     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [ToW:0] ToLimit = MEM_TIMEOUT[ToW:0];

    logic [2:0]       state_q, state_d;
    logic [8:0]       class_q, class_d;
    logic [ToW-1:0]   to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] retired_q;
    logic [1:0]       err_q, err_d;
    logic             halted_q;
    logic             retire;
    logic             to_hit;
    logic [8:0]       flags;
    logic [8:0]       dec_class;
    logic             mem_req, mem_we;

    assign flags = {r_i, i_i, i_load_i, i_jalr_i, s_i, sb_i, u_auipc_i, u_lui_i, uj_jal_i};

    // The current wait cycle is the last one allowed; mem_ready in this cycle still wins.
    assign to_hit = (MEM_TIMEOUT != 0) &&
                    (({1'b0, to_cnt_q} + {{ToW{1'b0}}, 1'b1}) == ToLimit);

    // Multi-hot flags resolve to the highest-priority set bit.
    always_comb begin
        dec_class = '0;
        for (int k = 0; k < 9; k++) begin
            if (flags[k]) begin
                dec_class    = '0;
                dec_class[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        class_d     = class_q;
        to_cnt_d    = '0;
        err_d       = err_q;
        retire      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        pc_sel_o    = 2'd0;
        reg_we_o    = 1'b0;
        wb_sel_o    = 2'd0;
        alu_src_a_o = 1'b0;
        alu_src_b_o = 1'b0;
        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_we_o = 1'b1;
                    state_d = StDecode;
                end else if (to_hit) begin
                    state_d = StHalt;
                    err_d   = 2'd2;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StDecode: begin
                class_d = dec_class;
                if (|flags) begin
                    state_d = StExec;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = StHalt;
                    err_d   = 2'd1;
`else
                    pc_we_o = 1'b1;
                    state_d = StFetch;
`endif
                end
            end
            StExec: begin
                alu_src_a_o = class_q[ClAuipc] | class_q[ClSb] | class_q[ClJal];
                alu_src_b_o = ~(class_q[ClR] | class_q[ClSb]);
                if (class_q[ClSb]) begin
                    pc_we_o  = 1'b1;
                    pc_sel_o = branch_taken_i ? 2'd1 : 2'd0;
                    retire   = 1'b1;
                    state_d  = StFetch;
                end else if (class_q[ClLoad] || class_q[ClS]) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                mem_req = 1'b1;
                mem_we  = class_q[ClS];
                if (mem.mem_ready) begin
                    if (class_q[ClS]) begin
                        pc_we_o = 1'b1;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (to_hit) begin
                    state_d = StHalt;
                    err_d   = 2'd2;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StWb: begin
                reg_we_o = 1'b1;
                pc_we_o  = 1'b1;
                retire   = 1'b1;
                state_d  = StFetch;
                if (class_q[ClLoad]) begin
                    wb_sel_o = 2'd1;
                end else if (class_q[ClJal] || class_q[ClJalr]) begin
                    wb_sel_o = 2'd2;
                end
                if (class_q[ClJal]) begin
                    pc_sel_o = 2'd1;
                end else if (class_q[ClJalr]) begin
                    pc_sel_o = 2'd2;
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            class_q   <= '0;
            to_cnt_q  <= '0;
            retired_q <= '0;
            err_q     <= 2'd0;
            halted_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            class_q  <= class_d;
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
            halted_q <= (state_d == StHalt);
            if (retire) begin
                retired_q <= retired_q + 1'b1;
            end
        end
    end

    assign mem.mem_req  = mem_req;
    assign mem.mem_we   = mem_we;
    assign state_o      = state_q;
    assign retired_o    = retired_q;
    assign err_cause_o  = err_q;
    assign halted_o     = halted_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
    localparam logic [8:0] FR     = 9'h100;
    localparam logic [8:0] FI     = 9'h080;
    localparam logic [8:0] FLD    = 9'h040;
    localparam logic [8:0] FJALR  = 9'h020;
    localparam logic [8:0] FS     = 9'h010;
    localparam logic [8:0] FSB    = 9'h008;
    localparam logic [8:0] FAUIPC = 9'h004;
    localparam logic [8:0] FLUI   = 9'h002;
    localparam logic [8:0] FJAL   = 9'h001;

    typedef struct {
        logic [8:0]  flags;
        logic        bt;
        logic        rdy;
        logic [20:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] flags = '0;
    logic       bt = 1'b0;
    logic       ir_we, pc_we, reg_we, alu_a, alu_b, halted;
    logic [1:0] pc_sel, wb_sel, err;
    logic [2:0] state;
    logic [3:0] retired;
    int         n_cmp = 0;
    int         n_bad = 0;
    vec_t       tbl[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .r_i            (flags[8]),
        .i_i            (flags[7]),
        .i_load_i       (flags[6]),
        .i_jalr_i       (flags[5]),
        .s_i            (flags[4]),
        .sb_i           (flags[3]),
        .u_auipc_i      (flags[2]),
        .u_lui_i        (flags[1]),
        .uj_jal_i       (flags[0]),
        .branch_taken_i (bt),
        .mem            (bus.master),
        .ir_we_o        (ir_we),
        .pc_we_o        (pc_we),
        .pc_sel_o       (pc_sel),
        .reg_we_o       (reg_we),
        .wb_sel_o       (wb_sel),
        .alu_src_a_o    (alu_a),
        .alu_src_b_o    (alu_b),
        .halted_o       (halted),
        .err_cause_o    (err),
        .state_o        (state),
        .retired_o      (retired)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] e(int st, int rq, int we, int ir, int pw, int ps, int rw,
                                      int ws, int a, int b, int h, int er, int rt);
        logic [2:0] s3 = st[2:0];
        logic [1:0] p2 = ps[1:0];
        logic [1:0] w2 = ws[1:0];
        logic [1:0] e2 = er[1:0];
        logic [3:0] r4 = rt[3:0];
        return {s3, rq[0], we[0], ir[0], pw[0], p2, rw[0], w2, a[0], b[0], h[0], e2, r4};
    endfunction

    function automatic logic [20:0] act_vec();
        return {state, bus.mem_req, bus.mem_we, ir_we, pc_we, pc_sel, reg_we, wb_sel,
                alu_a, alu_b, halted, err, retired};
    endfunction

    task automatic add(input logic [8:0] f, input logic b, input logic r, input logic [20:0] x);
        vec_t v;
        v.flags = f;
        v.bt    = b;
        v.rdy   = r;
        v.exp   = x;
        tbl.push_back(v);
    endtask

    // FETCH with zero-wait memory followed by DECODE of the given class.
    task automatic add_fd(input logic [8:0] f, input int rt);
        add('0, 1'b0, 1'b1, e(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, rt));
        add(f, 1'b0, 1'b1, e(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rt));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.mem_ready = 1'b1;
        // R type, zero wait
        add('0, 1'b0, 1'b1, e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add_fd(FR, 0);
        add('0, 1'b0, 1'b1, e(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add('0, 1'b0, 1'b1, e(5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        // Load, mem_ready delayed 3 cycles in MEM
        add_fd(FLD, 1);
        add('0, 1'b0, 1'b1, e(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        for (int k = 0; k < 3; k++) add('0, 1'b0, 1'b0, e(4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add('0, 1'b0, 1'b1, e(4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        add('0, 1'b0, 1'b1, e(5, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1));
        // Branch taken, then not taken
        add_fd(FSB, 2);
        add('0, 1'b1, 1'b1, e(3, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 2));
        add_fd(FSB, 3);
        add('0, 1'b0, 1'b1, e(3, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 3));
        // Store
        add_fd(FS, 4);
        add('0, 1'b0, 1'b1, e(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4));
        add('0, 1'b0, 1'b1, e(4, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4));
        // JAL
        add_fd(FJAL, 5);
        add('0, 1'b0, 1'b1, e(3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 5));
        add('0, 1'b0, 1'b1, e(5, 0, 0, 0, 1, 1, 1, 2, 0, 0, 0, 0, 5));
        // JALR
        add_fd(FJALR, 6);
        add('0, 1'b0, 1'b1, e(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6));
        add('0, 1'b0, 1'b1, e(5, 0, 0, 0, 1, 2, 1, 2, 0, 0, 0, 0, 6));
        // Multi-hot: AUIPC beats LUI and JAL
        add_fd(FAUIPC | FLUI | FJAL, 7);
        add('0, 1'b0, 1'b1, e(3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 7));
        add('0, 1'b0, 1'b1, e(5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 7));
        // Multi-hot: R beats SB
        add_fd(FR | FSB, 8);
        add('0, 1'b0, 1'b1, e(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8));
        add('0, 1'b0, 1'b1, e(5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 8));
        // Illegal opcode acts as NOP: PC+4, no retire
        add('0, 1'b0, 1'b1, e(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 9));
        add('0, 1'b0, 1'b1, e(2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 9));
        // LUI
        add_fd(FLUI, 9);
        add('0, 1'b0, 1'b1, e(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9));
        add('0, 1'b0, 1'b1, e(5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 9));
        // I type with one wait cycle in FETCH
        add('0, 1'b0, 1'b0, e(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10));
        add_fd(FI, 10);
        add('0, 1'b0, 1'b1, e(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 10));
        add('0, 1'b0, 1'b1, e(5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 10));

        // Reset state
        #11;
        chk("reset_state", 32'(act_vec()), 32'(e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            flags         = tbl[k].flags;
            bt            = tbl[k].bt;
            bus.mem_ready = tbl[k].rdy;
            #2;
            if (act_vec() !== tbl[k].exp) begin
                n_cmp++;
                n_bad++;
                $display("FAIL vec%0d: got %06h expected %06h", k, act_vec(), tbl[k].exp);
            end else begin
                n_cmp++;
            end
            tick(1);
        end
        chk("retired_after_table", 32'(retired), 32'd11);

        // Async reset in the middle of a MEM wait drops mem_req at once
        flags = FLD;
        bus.mem_ready = 1'b1;
        tick(3);
        bus.mem_ready = 1'b0;
        #2;
        chk("pre_rst_state", 32'(state), 32'd4);
        chk("pre_rst_req", 32'(bus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        flags = FR;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // 16 R instructions wrap the 4-bit counter
        tick(61);
        chk("retired_15", 32'(retired), 32'd15);
        tick(4);
        chk("retired_wrap", 32'(retired), 32'd0);
        chk("wrap_state", 32'(state), 32'd1);

        // mem_ready on the limit cycle wins over the timeout
        bus.mem_ready = 1'b0;
        tick(3);
        bus.mem_ready = 1'b1;
        #2;
        chk("limit_state", 32'(state), 32'd1);
        tick(1);
        chk("limit_wins", 32'(state), 32'd2);
        tick(3);
        chk("limit_retired", 32'(retired), 32'd1);

        // FETCH timeout
        bus.mem_ready = 1'b0;
        tick(3);
        chk("to_wait_state", 32'(state), 32'd1);
        tick(1);
        chk("to_halt_state", 32'(state), 32'd6);
        chk("to_err", 32'(err), 32'd2);
        chk("to_halted", 32'(halted), 32'd1);
        bus.mem_ready = 1'b1;
        tick(5);
        chk("halt_sticky", 32'(act_vec()), 32'(e(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
